// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the SRAM-like bridge: request struct, size codes,
// kseg0/kseg1 address mask and small address helpers.
// Optional feature macro used by the bridge: SRAM_BRIDGE_ALIGN_CHECK_EN.
package common;

  localparam int BUS_W = 32;

  // Transfer size encoding on both the datapath and bus sides
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // kseg0/kseg1 windows map onto physical memory by clearing bits [31:29]
  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  typedef struct packed {
    logic             req;
    logic             wr;
    logic [1:0]       size;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } sram_req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

  function automatic logic [31:0] to_phys(input logic [31:0] va);
    return (va[31:30] == 2'b10) ? (va & KSEG_MASK) : va;
  endfunction

endpackage

// File: rtl/sram_bridge_tagq.sv
// In-order tag FIFO remembering whether each outstanding bus transaction
// is a write. Pointers wrap modulo DEPTH; count spans 0..DEPTH.
module sram_bridge_tagq #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          push_tag,
  input  logic          pop,
  output logic          pop_tag,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_tag = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointer and occupancy update; simultaneous push and pop keep count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_bridge.sv
// Bridge from a datapath memory request port to an SRAM-like bus master.
// Translates kseg addresses, limits outstanding transactions to DEPTH and
// returns completions in issue order with zero latency on bus_data_ok.
// Define SRAM_BRIDGE_ALIGN_CHECK_EN to reject misaligned requests locally.
module sram_bridge
  import common::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_wr,
  input  logic [1:0]    req_size,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_wdata,
  output logic          req_ready,
  output logic          resp_valid,
  output logic          resp_wr,
  output logic          resp_err,
  output logic [AW-1:0] resp_rdata,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [AW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [AW-1:0] bus_rdata,
  output logic          busy,
  output logic          proto_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop_tag;
  logic          push;
  logic          pop;
  logic          misaligned;
  logic          mis_done;
  logic          proto_q;
  logic [31:0]   va;
  sram_req_t     bus_pkt;

  assign va = 32'(req_addr);

`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign mis_done   = !reset && req_valid && misaligned && empty;
`else
  assign misaligned = 1'b0;
  assign mis_done   = 1'b0;
`endif

  // Assemble the outgoing bus request; blocked when full, in reset or misaligned
  always_comb begin
    bus_pkt       = '0;
    bus_pkt.req   = !reset && req_valid && !full && !misaligned;
    bus_pkt.wr    = req_wr;
    bus_pkt.size  = req_size;
    bus_pkt.addr  = to_phys(va);
    bus_pkt.wdata = 32'(req_wdata);
  end

  assign bus_req   = bus_pkt.req;
  assign bus_wr    = bus_pkt.wr;
  assign bus_size  = bus_pkt.size;
  assign bus_addr  = AW'(bus_pkt.addr);
  assign bus_wdata = AW'(bus_pkt.wdata);

  assign push      = bus_pkt.req && bus_addr_ok;
  assign pop       = !reset && bus_data_ok && !empty;
  assign req_ready = push || mis_done;
  assign busy      = (count != '0);
  assign proto_err = proto_q;

  // Completion mux: bus data return has priority, local error completion otherwise
  always_comb begin
    resp_valid = 1'b0;
    resp_wr    = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (pop) begin
      resp_valid = 1'b1;
      resp_wr    = pop_tag;
      resp_rdata = bus_rdata;
    end else if (mis_done) begin
      resp_valid = 1'b1;
      resp_wr    = req_wr;
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
      resp_err   = 1'b1;
`endif
    end
  end

  // Sticky flag for data_ok arriving with nothing outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_q <= 1'b0;
    end else if (bus_data_ok && empty) begin
      proto_q <= 1'b1;
    end
  end

  sram_bridge_tagq #(.DEPTH(DEPTH)) u_tagq (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (req_wr),
    .pop      (pop),
    .pop_tag  (pop_tag),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: directed scenarios plus randomized
// traffic, checked by a reference model and an in-order response scoreboard.
module tb_sram_bridge;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_wr = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_wr;
  logic          resp_err;
  logic [AW-1:0] resp_rdata;
  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [AW-1:0] bus_wdata;
  logic          bus_addr_ok = 1'b0;
  logic          bus_data_ok = 1'b0;
  logic [AW-1:0] bus_rdata = '0;
  logic          busy;
  logic          proto_err;

  sram_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_size    (req_size),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_wr     (resp_wr),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  bit   tag_q[$];
  bit   proto_m = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit active = 1'b0;

  logic        exp_bus_req;
  logic        exp_ready;
  logic        exp_busy;
  logic        exp_proto;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_wr;
  logic [1:0]  exp_size;

  function automatic logic [31:0] model_phys(input logic [31:0] a);
    if ((a >> 30) == 32'd2) return a % 32'h2000_0000;
    return a;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model
  task automatic apply_stimulus(input logic rst, input logic rv, input logic wr,
                                input logic [1:0] sz, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic aok,
                                input logic dok, input logic [31:0] rd);
    int   n;
    bit   mis;
    bit   acc;
    bit   mis_done;
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    req_valid   = rv;
    req_wr      = wr;
    req_size    = sz;
    req_addr    = addr;
    req_wdata   = wdata;
    bus_addr_ok = aok;
    bus_data_ok = dok;
    bus_rdata   = rd;
    cyc++;
    n         = tag_q.size();
    exp_busy  = (n != 0);
    exp_proto = proto_m;
    exp_addr  = model_phys(addr);
    exp_wdata = wdata;
    exp_wr    = wr;
    exp_size  = sz;
    if (rst) begin
      exp_bus_req = 1'b0;
      exp_ready   = 1'b0;
      tag_q.delete();
      proto_m = 1'b0;
    end else begin
      mis = 1'b0;
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
      mis = model_misaligned(sz, addr);
`endif
      exp_bus_req = rv && !mis && (n < DEPTH);
      acc         = exp_bus_req && aok;
      mis_done    = rv && mis && (n == 0);
      exp_ready   = acc || mis_done;
      if (dok && n > 0) begin
        e.cyc = cyc; e.wr = tag_q.pop_front(); e.rdata = rd; e.err = 1'b0;
        exp_q.push_back(e);
      end else if (dok) begin
        proto_m = 1'b1;
      end
      if (mis_done) begin
        e.cyc = cyc; e.wr = wr; e.rdata = 32'h0; e.err = 1'b1;
        exp_q.push_back(e);
      end
      if (acc) tag_q.push_back(wr);
    end
    active = 1'b1;
  endtask

  // Compare the DUT's combinational and registered outputs mid-cycle
  task automatic check_output();
    exp_t e;
    check_val("bus_req", bus_req, exp_bus_req);
    check_val("req_ready", req_ready, exp_ready);
    check_val("busy", busy, exp_busy);
    check_val("proto_err", proto_err, exp_proto);
    check_val("bus_addr", bus_addr, exp_addr);
    check_val("bus_wdata", bus_wdata, exp_wdata);
    check_val("bus_wr", bus_wr, exp_wr);
    check_val("bus_size", bus_size, exp_size);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check_val("resp_valid", resp_valid, 1'b1);
      check_val("resp_rdata", resp_rdata, e.rdata);
      check_val("resp_err", resp_err, e.err);
      if (!e.err) check_val("resp_wr", resp_wr, e.wr);
    end else begin
      check_val("resp_valid_idle", resp_valid, 1'b0);
    end
  endtask

  // Monitor: sample away from the rising edge and score responses
  always @(negedge clk) begin
    if (active) check_output();
  end

  initial begin
    logic [31:0] a;
    $display("[TB] starting sram_bridge bench, DEPTH=%0d", DEPTH);
    repeat (3) apply_stimulus(1, 1, 0, 2, 32'h9FC0_0004, 0, 1, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // kseg read with data one cycle after address acceptance
    apply_stimulus(0, 1, 0, 2, 32'h9FC0_0004, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    apply_stimulus(0, 0, 0, 0, 32'hBFC0_0010, 0, 0, 0, 0);

    // three back-to-back reads against DEPTH outstanding
    apply_stimulus(0, 1, 0, 2, 32'h0000_1000, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 2, 32'h0000_1004, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 2, 32'h0000_1008, 0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 2, 32'h0000_1008, 0, 1, 1, 32'hAAAA_0001);
    apply_stimulus(0, 1, 0, 2, 32'h0000_1008, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0002);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0003);

    // accept and data_ok in the same cycle with one outstanding
    apply_stimulus(0, 1, 1, 2, 32'h8000_0040, 32'h5555_AAAA, 1, 0, 0);
    apply_stimulus(0, 1, 0, 1, 32'h8000_0042, 0, 1, 1, 32'h0BAD_F00D);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hC0DE_0001);

    // spurious data_ok while idle, then reset clears the flag
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset with two outstanding discards them; later data_ok is spurious
    apply_stimulus(0, 1, 0, 2, 32'h0000_2000, 0, 1, 0, 0);
    apply_stimulus(0, 1, 1, 2, 32'h0000_2004, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 2, 32'h0000_2008, 0, 1, 1, 32'h1111_1111);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
    // misaligned word write waits for the outstanding access, then errors
    apply_stimulus(0, 1, 1, 2, 32'h0000_0100, 0, 1, 0, 0);
    apply_stimulus(0, 1, 1, 2, 32'h0000_0002, 0, 1, 0, 0);
    apply_stimulus(0, 1, 1, 2, 32'h0000_0002, 0, 1, 1, 32'h3333_3333);
    apply_stimulus(0, 1, 1, 2, 32'h0000_0002, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      apply_stimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), a, $urandom,
                     1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, $urandom);
    end

    // drain whatever is left outstanding
    for (int i = 0; i < DEPTH + 2; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, $urandom);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_val("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
